// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, indices and types for the writeback register file
package wb_pkg;

   localparam int XLEN       = 32;
   localparam int REG_CNT    = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [XLEN-1:0]       word_t;
   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   localparam reg_idx_t SP_IDX = reg_idx_t'(2);
   localparam reg_idx_t X0_IDX = reg_idx_t'(0);

   // A write retires only when enabled and not aimed at the hardwired zero register.
   function automatic logic is_retire(input logic we, input reg_idx_t rd);
      return we && (rd != X0_IDX);
   endfunction

endpackage

// File: rtl/wb_mux32.sv
// rtl/wb_mux32.sv - 2:1 32-bit writeback source select (sel=1 picks memory data)
module wb_mux32
   import wb_pkg::*;
(
   input  logic  sel,
   input  word_t alu,
   input  word_t mem,
   output word_t y
);

   assign y = sel ? mem : alu;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 32x32 register file with writeback mux and retire counter
// Optional macro WB_REGFILE_BYPASS_EN forwards the in-flight write to same-index reads.
module wb_regfile
   import wb_pkg::*;
#(
   parameter int          CNT_W    = 32,
   parameter logic [31:0] RESET_SP = 32'h0000_0000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             RegWrite_i,
   input  logic             MemtoReg_i,
   input  logic [31:0]      ALUResult_i,
   input  logic [31:0]      DATARd_i,
   input  logic [4:0]       Rd_i,
   input  logic [4:0]       RS1addr_i,
   input  logic [4:0]       RS2addr_i,
   output logic [31:0]      RS1data_o,
   output logic [31:0]      RS2data_o,
   output logic [31:0]      WBdata_o,
   output logic [CNT_W-1:0] WBcount_o
);

   word_t regs [REG_CNT];
   word_t wb_data;
   logic  wr_en;

   wb_mux32 u_wb_mux (
      .sel (MemtoReg_i),
      .alu (ALUResult_i),
      .mem (DATARd_i),
      .y   (wb_data)
   );

   assign WBdata_o = wb_data;
   assign wr_en    = is_retire(RegWrite_i, Rd_i);

   // Reset has priority, so a write presented alongside it is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < REG_CNT; i++) begin
            regs[i] <= (reg_idx_t'(i) == SP_IDX) ? RESET_SP : '0;
         end
         WBcount_o <= '0;
      end else if (wr_en) begin
         regs[Rd_i] <= wb_data;
         WBcount_o  <= WBcount_o + CNT_W'(1);
      end
   end

   always_comb begin
      RS1data_o = (RS1addr_i == X0_IDX) ? '0 : regs[RS1addr_i];
      RS2data_o = (RS2addr_i == X0_IDX) ? '0 : regs[RS2addr_i];
`ifdef WB_REGFILE_BYPASS_EN
      if (wr_en && !rst_i && (RS1addr_i == Rd_i)) RS1data_o = wb_data;
      if (wr_en && !rst_i && (RS2addr_i == Rd_i)) RS2data_o = wb_data;
`endif
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized bench for wb_regfile against an array-based reference model
module tb_wb_regfile;

   localparam int          CNT_W = 4;
   localparam logic [31:0] SP0   = 32'h0000_1000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             we = 1'b0;
   logic             m2r = 1'b0;
   logic [31:0]      alu = '0;
   logic [31:0]      mem = '0;
   logic [4:0]       rd = '0;
   logic [4:0]       rs1 = '0;
   logic [4:0]       rs2 = '0;
   logic [31:0]      rs1_data;
   logic [31:0]      rs2_data;
   logic [31:0]      wb_data;
   logic [CNT_W-1:0] wb_count;

   int checks = 0;
   int errors = 0;

`ifdef WB_REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   wb_regfile #(.CNT_W(CNT_W), .RESET_SP(SP0)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .RegWrite_i  (we),
      .MemtoReg_i  (m2r),
      .ALUResult_i (alu),
      .DATARd_i    (mem),
      .Rd_i        (rd),
      .RS1addr_i   (rs1),
      .RS2addr_i   (rs2),
      .RS1data_o   (rs1_data),
      .RS2data_o   (rs2_data),
      .WBdata_o    (wb_data),
      .WBcount_o   (wb_count)
   );

   always #5 clk = ~clk;

   // Reference model: architectural state as a plain array and an integer count.
   logic [31:0] m_regs [32];
   int          m_cnt = 0;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_regs[2] = SP0;
         m_cnt     = 0;
         m_valid   = 1'b1;
      end else if (we && rd != 5'd0) begin
         m_regs[rd] = m2r ? mem : alu;
         m_cnt      = (m_cnt + 1) % (1 << CNT_W);
      end
   end

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      logic [31:0] wbv;
      wbv = m2r ? mem : alu;
      if (a == 5'd0) return 32'd0;
      if (BYPASS && !rst && we && rd != 5'd0 && a == rd) return wbv;
      return m_regs[a];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_wbdata", wb_data, m2r ? mem : alu);
         check("model_rs1", rs1_data, exp_read(rs1));
         check("model_rs2", rs2_data, exp_read(rs2));
         check("model_count", 32'(wb_count), 32'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset, then sample the stack pointer and an untouched register.
      tick();
      rst = 1'b0; rs1 = 5'd2; rs2 = 5'd5;
      @(negedge clk);
      check("reset_sp", rs1_data, 32'h0000_1000);
      check("reset_x5", rs2_data, 32'd0);
      check("reset_count", 32'(wb_count), 32'd0);

      tick();
      we = 1'b1; m2r = 1'b0; alu = 32'hDEAD_BEEF; rd = 5'd5;
      tick();
      we = 1'b0; rs1 = 5'd5;
      @(negedge clk);
      check("alu_write_x5", rs1_data, 32'hDEAD_BEEF);
      check("alu_write_count", 32'(wb_count), 32'd1);

      tick();
      we = 1'b1; m2r = 1'b1; mem = 32'h0000_00A5; alu = 32'h1; rd = 5'd0; rs1 = 5'd0;
      @(negedge clk);
      check("x0_wbdata", wb_data, 32'h0000_00A5);
      tick();
      we = 1'b0;
      @(negedge clk);
      check("x0_read", rs1_data, 32'd0);
      check("x0_count", 32'(wb_count), 32'd1);

      // Seed x7, then overwrite it while reading it in the same cycle.
      tick();
      we = 1'b1; m2r = 1'b0; alu = 32'h0000_0055; rd = 5'd7;
      tick();
      alu = 32'h1234_5678; rs2 = 5'd7;
      @(negedge clk);
      check("same_cycle_rs2", rs2_data, BYPASS ? 32'h1234_5678 : 32'h0000_0055);
      tick();
      we = 1'b0;
      @(negedge clk);
      check("after_write_rs2", rs2_data, 32'h1234_5678);
      check("after_write_count", 32'(wb_count), 32'd3);

      for (int n = 0; n < 400; n++) begin
         tick();
         rst = ($urandom_range(0, 39) == 0);
         we  = ($urandom_range(0, 3) != 0);
         m2r = $urandom_range(0, 1) == 1;
         alu = $urandom;
         mem = $urandom;
         rd  = 5'($urandom_range(0, 31));
         rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      end

      tick();
      rst = 1'b1; we = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; m2r = 1'b0; alu = 32'h100 + 32'(i); rd = 5'(1 + i);
         tick();
      end
      we = 1'b0; rs1 = 5'd16;
      @(negedge clk);
      check("wrap_count", 32'(wb_count), 32'd0);
      check("wrap_last_x16", rs1_data, 32'h0000_010F);

      tick();
      rst = 1'b1; we = 1'b1; m2r = 1'b0; alu = 32'h0000_0ABC; rd = 5'd3;
      tick();
      rst = 1'b0; we = 1'b0; rs1 = 5'd3; rs2 = 5'd2;
      @(negedge clk);
      check("rst_drop_x3", rs1_data, 32'd0);
      check("rst_drop_count", 32'(wb_count), 32'd0);
      check("rst_sp_again", rs2_data, 32'h0000_1000);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter CNT_W, default 32, width of the writeback retire counter.
REQ-002 Parameter RESET_SP, default 32'h0000_0000, reset value of x2 (stack pointer); every other register resets to 0.
REQ-003 Port clk_i, input, 1, the single clock; all state updates occur on the rising edge.
REQ-004 Port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 Port RegWrite_i, input, 1, writeback enable from the MEM/WB stage register.
REQ-006 Port MemtoReg_i, input, 1, writeback source select: 1 = memory load data, 0 = ALU result.
REQ-007 Port ALUResult_i, input, 32, ALU result carried through MEM/WB.
REQ-008 Port DATARd_i, input, 32, data-memory read data carried through MEM/WB.
REQ-009 Port Rd_i, input, 5, destination register index.
REQ-010 Port RS1addr_i / RS2addr_i, input, 5 each, ID-stage read indices.
REQ-011 Port RS1data_o / RS2data_o, output, 32 each, ID-stage read data.
REQ-012 Port WBdata_o, output, 32, selected writeback value, for the forwarding unit.
REQ-013 Port WBcount_o, output, CNT_W, number of architectural register writes retired.

Function
REQ-014 WBdata_o SHALL equal DATARd_i when MemtoReg_i=1, else ALUResult_i, combinationally, regardless of RegWrite_i.
REQ-015 Register file SHALL hold 32 x 32-bit entries; x0 SHALL always read 0 and SHALL never be written.
REQ-016 On a rising edge with rst_i=0, RegWrite_i=1 and Rd_i!=0, entry Rd_i SHALL take WBdata_o; the value is visible one cycle later with zero-cycle bypass disabled.
REQ-017 RegWrite_i=1 with Rd_i=0 SHALL change no state and SHALL NOT increment WBcount_o.
REQ-018 Reads SHALL be combinational: RSxdata_o = entry[RSxaddr_o] (0 for index 0), subject to REQ-024.
REQ-019 WBcount_o SHALL increment by 1 on each edge where a write per REQ-016 occurs, wrapping from 2^CNT_W-1 to 0.
REQ-020 RS1addr_i = RS2addr_i SHALL return identical data on both ports.

Reset
REQ-021 With rst_i=1 at a rising edge: x2 <= RESET_SP, all other entries <= 0, WBcount_o <= 0; a simultaneous write request SHALL be discarded.
REQ-022 Reset asserted mid-stream SHALL take effect at the very next edge; the first write accepted is the one presented on the first edge with rst_i=0.

Configuration
REQ-023 Macro WB_REGFILE_BYPASS_EN SHALL select internal write-to-read bypass.
REQ-024 Defined: when RegWrite_i=1, Rd_i!=0, rst_i=0 and RSxaddr_i=Rd_i, RSxdata_o SHALL equal WBdata_o in the same cycle; undefined: RSxdata_o SHALL return the stored (old) value until the edge completes.

Structure
REQ-025 Shared package wb_pkg SHALL hold XLEN=32, REG_CNT=32, REG_ADDR_W=5, SP_IDX=2, and X0_IDX=0.
REQ-026 Writeback source select SHALL be one sub-module, wb_mux32 (2:1, 32-bit), instantiated once; storage, bypass, and counter live in wb_regfile.

Verification
REQ-027 rst_i=1 for 1 cycle, RESET_SP=32'h0000_1000 -> read x2=32'h0000_1000, x5=0, WBcount_o=0.
REQ-028 RegWrite=1, MemtoReg=0, ALUResult=32'hDEAD_BEEF, Rd=5; next cycle read RS1addr=5 -> 32'hDEAD_BEEF, WBcount_o=1.
REQ-029 RegWrite=1, MemtoReg=1, DATARd=32'h0000_00A5, ALUResult=32'h1, Rd=0 -> x0 reads 0, WBcount_o unchanged, WBdata_o=32'hA5.
REQ-030 Same-cycle write Rd=7 value 32'h1234_5678 with RS2addr=7 -> RS2data_o=32'h1234_5678 with WB_REGFILE_BYPASS_EN, old value without it.
REQ-031 CNT_W=4, 16 valid writes -> WBcount_o wraps to 0; then rst_i=1 concurrent with RegWrite=1, Rd=3 -> x3=0, WBcount_o=0.
